skip_logic: RTL and testbench

- Carry-skip bypass stage for one block of a carry-skip adder, N bits wide.
- Forms the block group-propagate from operands a and b. It merges the block ripple carry-out (cout) with the block carry-in (cin) to produce the carry into the next block (cin_next).
- Primary output is purely combinational so it chains block to block.
- A registered copy with valid tracking is provided for pipelined adders.

---
 rtl/skip_logic.sv | 57 +++++
 tb/tb_skip_logic.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/skip_logic.sv
// Carry-skip bypass stage for one block of a carry-skip adder.
// Optional skip counter enabled by defining SKIP_LOGIC_SKIP_COUNT_EN.
module skip_logic #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         cout,
    input  logic         in_valid,
    output logic         cin_next,
    output logic         group_p,
    output logic         cin_next_q,
    output logic         skip_q,
    output logic         out_valid
`ifdef SKIP_LOGIC_SKIP_COUNT_EN
    ,
    output logic [15:0]  skip_count
`endif
);

    logic [N-1:0] p;
    logic         skip;

    assign p        = a | b;
    assign group_p  = &p;
    assign cin_next = cout | (group_p & cin);
    // Carry asserted by the bypass alone, not by the ripple chain
    assign skip     = group_p & cin & ~cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            cin_next_q <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                cin_next_q <= cin_next;
                skip_q     <= skip;
            end
        end
    end

`ifdef SKIP_LOGIC_SKIP_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_count <= 16'h0000;
        end else if (in_valid && skip && (skip_count != 16'hFFFF)) begin
            skip_count <= skip_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_skip_logic.sv
// Directed self-checking bench for skip_logic (N=1 and N=4 instances).
module tb_skip_logic;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, cin1, cout1, iv1;
    logic [3:0] a4, b4;
    logic       cin4, cout4, iv4;
    logic       cn1, gp1, cnq1, skq1, ov1;
    logic       cn4, gp4, cnq4, skq4, ov4;
`ifdef SKIP_LOGIC_SKIP_COUNT_EN
    logic [15:0] cnt1, cnt4;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    skip_logic #(.N(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .cout(cout1),
        .in_valid(iv1), .cin_next(cn1), .group_p(gp1),
        .cin_next_q(cnq1), .skip_q(skq1), .out_valid(ov1)
`ifdef SKIP_LOGIC_SKIP_COUNT_EN
        , .skip_count(cnt1)
`endif
    );

    skip_logic #(.N(4)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .cout(cout4),
        .in_valid(iv4), .cin_next(cn4), .group_p(gp4),
        .cin_next_q(cnq4), .skip_q(skq4), .out_valid(ov4)
`ifdef SKIP_LOGIC_SKIP_COUNT_EN
        , .skip_count(cnt4)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set1(input logic a, input logic b, input logic ci,
                        input logic co, input logic v);
        a1 = a; b1 = b; cin1 = ci; cout1 = co; iv1 = v;
    endtask

    initial begin
        rst = 1'b1;
        set1(0, 0, 0, 0, 0);
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; cout4 = 1'b0; iv4 = 1'b0;
        #2;
        check("reset_out_valid", {15'd0, ov1}, 16'd0);
        check("reset_cin_next_q", {15'd0, cnq1}, 16'd0);
        check("reset_skip_q", {15'd0, skq1}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // N=1 exhaustive: index bits are {a, b, cin, cout}
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            logic exp;
            v = 4'(i);
            set1(v[3], v[2], v[1], v[0], 0);
            exp = v[0] | ((v[3] | v[2]) & v[1]);
            #1;
            check($sformatf("exh_cin_next_%0d", i), {15'd0, cn1}, {15'd0, exp});
            check($sformatf("exh_group_p_%0d", i), {15'd0, gp1},
                  {15'd0, v[3] | v[2]});
        end

        set1(1, 1, 1, 0, 0); #1;
        check("spot_11_c1_o0", {15'd0, cn1}, 16'd1);
        set1(0, 0, 1, 0, 0); #1;
        check("spot_00_c1_o0", {15'd0, cn1}, 16'd0);
        set1(1, 1, 0, 0, 0); #1;
        check("spot_11_c0_o0", {15'd0, cn1}, 16'd0);
        set1(0, 1, 0, 1, 0); #1;
        check("spot_01_c0_o1", {15'd0, cn1}, 16'd1);

        a4 = 4'b1010; b4 = 4'b0101; cin4 = 1'b1; cout4 = 1'b0; #1;
        check("n4_prop_group_p", {15'd0, gp4}, 16'd1);
        check("n4_prop_cin_next", {15'd0, cn4}, 16'd1);
        a4 = 4'b1000; b4 = 4'b0001; #1;
        check("n4_kill_group_p", {15'd0, gp4}, 16'd0);
        check("n4_kill_cin_next", {15'd0, cn4}, 16'd0);
        cout4 = 1'b1; #1;
        check("n4_kill_cout", {15'd0, cn4}, 16'd1);

        @(negedge clk);
        set1(1, 0, 1, 0, 1);
        @(posedge clk); #1;
        check("reg_out_valid", {15'd0, ov1}, 16'd1);
        check("reg_cin_next_q", {15'd0, cnq1}, 16'd1);
        check("reg_skip_q", {15'd0, skq1}, 16'd1);

        @(negedge clk);
        set1(0, 0, 0, 1, 0);
        @(posedge clk); #1;
        check("hold_out_valid", {15'd0, ov1}, 16'd0);
        check("hold_cin_next_q", {15'd0, cnq1}, 16'd1);
        check("hold_skip_q", {15'd0, skq1}, 16'd1);

        @(negedge clk);
        set1(0, 0, 0, 0, 1);
        @(posedge clk); #1;
        check("zero_cin_next_q", {15'd0, cnq1}, 16'd0);
        check("zero_skip_q", {15'd0, skq1}, 16'd0);

        @(negedge clk);
        set1(1, 1, 1, 0, 1);
        @(posedge clk); #1;
        check("pre_rst_out_valid", {15'd0, ov1}, 16'd1);
        check("pre_rst_cin_next_q", {15'd0, cnq1}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", {15'd0, ov1}, 16'd0);
        check("async_cin_next_q", {15'd0, cnq1}, 16'd0);
        check("async_skip_q", {15'd0, skq1}, 16'd0);
        check("rst_comb_cin_next", {15'd0, cn1}, 16'd1);
        set1(0, 0, 1, 0, 1); #1;
        check("rst_comb_kill", {15'd0, cn1}, 16'd0);
        set1(0, 0, 1, 1, 1); #1;
        check("rst_comb_cout", {15'd0, cn1}, 16'd1);
        @(posedge clk); #1;
        check("rst_edge_out_valid", {15'd0, ov1}, 16'd0);

        @(negedge clk);
        rst = 1'b0;
        set1(1, 1, 1, 0, 0);
        @(posedge clk); #1;
        check("post_rst_idle_valid", {15'd0, ov1}, 16'd0);
        check("post_rst_idle_q", {15'd0, cnq1}, 16'd0);
        @(negedge clk);
        set1(0, 0, 1, 1, 1);
        @(posedge clk); #1;
        check("first_valid", {15'd0, ov1}, 16'd1);
        check("first_cin_next_q", {15'd0, cnq1}, 16'd1);
        check("first_skip_q", {15'd0, skq1}, 16'd0);

`ifdef SKIP_LOGIC_SKIP_COUNT_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("cnt_reset", cnt1, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        set1(1, 0, 1, 0, 1);
        repeat (3) @(negedge clk);
        set1(1, 0, 1, 1, 1);
        @(negedge clk);
        check("cnt_three", cnt1, 16'd3);
        set1(1, 0, 1, 0, 0);
        @(negedge clk);
        check("cnt_idle_hold", cnt1, 16'd3);
        set1(1, 0, 1, 0, 1);
        repeat (65531) @(negedge clk);
        check("cnt_fffe", cnt1, 16'hFFFE);
        repeat (2) @(negedge clk);
        check("cnt_saturate", cnt1, 16'hFFFF);
        set1(0, 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
